// File: rtl/mips_multicycle.sv
// Multicycle MIPS subset core (lw/sw/R-type/beq/addi/j) with one shared memory port.
// Moore FSM: every memory request is held until mem_ready, so addr/we/wdata stay stable across wait cycles.
module mips_multicycle #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        halted
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
        ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t      r_state;
    state_t      w_next;
    logic        r_run;
    logic [31:0] r_pc, r_ir, r_a, r_b, r_aluout, r_mdr;
    logic [31:0] r_rf [32];

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [31:0] w_imm_sx, w_rs_val, w_rt_val, w_alu_res;
    logic        w_funct_ok, w_done;
    logic        w_rf_we;
    logic [4:0]  w_rf_waddr;
    logic [31:0] w_rf_wdata;

    assign w_op     = r_ir[31:26];
    assign w_rs     = r_ir[25:21];
    assign w_rt     = r_ir[20:16];
    assign w_rd     = r_ir[15:11];
    assign w_funct  = r_ir[5:0];
    assign w_imm_sx = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_rs_val = (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
    assign w_rt_val = (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];

    // r_run holds the first request off until one edge after reset releases
    assign mem_req   = r_run && (r_state == FETCH || r_state == MEMRD || r_state == MEMWR);
    assign mem_we    = r_run && (r_state == MEMWR);
    assign mem_addr  = (r_state == FETCH) ? r_pc : r_aluout;
    assign mem_wdata = r_b;
    assign w_done    = mem_req && mem_ready;
    assign pc        = r_pc;
    assign halted    = (r_state == HALT);

    always_comb begin
        w_alu_res  = 32'd0;
        w_funct_ok = 1'b1;
        case (w_funct)
            6'h20:   w_alu_res = r_a + r_b;
            6'h22:   w_alu_res = r_a - r_b;
            6'h24:   w_alu_res = r_a & r_b;
            6'h25:   w_alu_res = r_a | r_b;
            6'h2A:   w_alu_res = {31'd0, $signed(r_a) < $signed(r_b)};
            default: w_funct_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_run   <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH:  if (w_done) w_next = DECODE;
            DECODE: begin
                case (w_op)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_RTYPE:     w_next = EXEC;
                    OP_BEQ:       w_next = BRANCH;
                    OP_ADDI:      w_next = ADDIEX;
                    OP_J:         w_next = JUMP;
                    default:      w_next = HALT_ON_ILLEGAL ? HALT : FETCH;
                endcase
            end
            MEMADR: w_next = (w_op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (w_done) w_next = MEMWB;
            MEMWR:  if (w_done) w_next = FETCH;
            EXEC:   w_next = w_funct_ok ? ALUWB : (HALT_ON_ILLEGAL ? HALT : FETCH);
            ADDIEX: w_next = ADDIWB;
            MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: w_next = FETCH;
            HALT:   w_next = HALT;
            default: w_next = FETCH;
        endcase
    end

    always_comb begin
        w_rf_we    = 1'b0;
        w_rf_waddr = w_rt;
        w_rf_wdata = r_aluout;
        case (r_state)
            MEMWB:  begin w_rf_we = 1'b1; w_rf_wdata = r_mdr; end
            ALUWB:  begin w_rf_we = 1'b1; w_rf_waddr = w_rd; end
            ADDIWB: w_rf_we = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) r_rf[i] <= 32'd0;
        end else if (w_rf_we && w_rf_waddr != 5'd0) begin
            r_rf[w_rf_waddr] <= w_rf_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_ir     <= 32'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_aluout <= 32'd0;
            r_mdr    <= 32'd0;
        end else begin
            case (r_state)
                FETCH: if (w_done) begin
                    r_ir <= mem_rdata;
                    r_pc <= r_pc + 32'd4;
                end
                DECODE: begin
                    r_a      <= w_rs_val;
                    r_b      <= w_rt_val;
                    r_aluout <= r_pc + {w_imm_sx[29:0], 2'b00};
                end
                MEMADR, ADDIEX: r_aluout <= r_a + w_imm_sx;
                MEMRD:  if (w_done) r_mdr <= mem_rdata;
                EXEC:   r_aluout <= w_alu_res;
                BRANCH: if (r_a == r_b) r_pc <= r_aluout;
                JUMP:   r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle: per-instruction vector table plus reset/branch/halt sequences.
module tb_mips_multicycle;

    logic        clk = 1'b0;
    logic        reset, rst2;
    logic [31:0] pc, mem_addr, mem_wdata, mem_rdata;
    logic        mem_req, mem_we, mem_ready, halted;
    logic [31:0] pc2, addr2, wdata2, rdata2;
    logic        req2, we2, halted2;
    logic [31:0] mem [0:1023];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[11:2]];
    assign rdata2    = mem[addr2[11:2]];

    mips_multicycle #(.RESET_PC(32'h100), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .reset(reset), .pc(pc), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .halted(halted)
    );

    mips_multicycle #(.RESET_PC(32'h100), .HALT_ON_ILLEGAL(1'b0)) dut2 (
        .clk(clk), .reset(rst2), .pc(pc2), .mem_req(req2), .mem_we(we2),
        .mem_addr(addr2), .mem_wdata(wdata2), .mem_ready(1'b1),
        .mem_rdata(rdata2), .halted(halted2)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          fw;     // fetch wait cycles
        int          dw;     // data-access wait cycles
        int          cyc;
        logic [31:0] npc;
        bit          data;
        bit          we;
        logic [31:0] daddr;
        logic [31:0] wdata;
    } vec_t;

    function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction
    function automatic logic [31:0] enc_j(logic [25:0] t);
        return {6'd2, t};
    endfunction

    function automatic vec_t mk(logic [31:0] p, logic [31:0] ins, int fw, int dw, int cyc,
                                logic [31:0] npc, bit data, bit we, logic [31:0] da, logic [31:0] wd);
        vec_t v;
        v.pc = p; v.instr = ins; v.fw = fw; v.dw = dw; v.cyc = cyc; v.npc = npc;
        v.data = data; v.we = we; v.daddr = da; v.wdata = wd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered at the negedge where this instruction's fetch is first visible;
    // returns at the negedge where the following fetch is first visible.
    task automatic run_instr(input vec_t v, input int idx);
        int cycles, fw, dw, dcyc, dmatch, exp_d;
        bit fdone, just_f;
        string tag;
        tag = $sformatf("row%0d@%0h", idx, v.pc);
        chk({tag, " fetch"}, {30'd0, mem_req, mem_we, mem_addr}, {30'd0, 1'b1, 1'b0, v.pc});
        cycles = 0; fw = v.fw; dw = v.dw; dcyc = 0; dmatch = 0; fdone = 0; just_f = 0;
        while (1) begin
            if (mem_req && !fdone) begin
                mem_ready = (fw == 0);
                if (fw == 0) begin fdone = 1; just_f = 1; end
                else fw--;
            end else if (mem_req) begin
                dcyc++;
                if (mem_addr == v.daddr && mem_we == v.we && (!v.we || mem_wdata == v.wdata))
                    dmatch++;
                mem_ready = (dw == 0);
                if (dw > 0) dw--;
            end else begin
                mem_ready = 1'b1;
            end
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (just_f) begin
                chk({tag, " pc_after_fetch"}, 64'(pc), 64'(v.pc + 32'd4));
                just_f = 0;
            end
            if (fdone && mem_req && !mem_we && mem_addr == pc) break;
            if (cycles >= 40) begin
                n_cmp++; n_err++;
                $display("FAIL %s timeout: got no next fetch in %0d cycles, required %0d", tag, cycles, v.cyc);
                break;
            end
        end
        mem_ready = 1'b1;
        exp_d = v.data ? v.dw + 1 : 0;
        chk({tag, " cycles"}, 64'(cycles), 64'(v.cyc));
        chk({tag, " next_pc"}, 64'(pc), 64'(v.npc));
        chk({tag, " data_cycles"}, 64'(dcyc), 64'(exp_d));
        chk({tag, " data_match"}, 64'(dmatch), 64'(exp_d));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        vec_t v;
        int fa[4];
        int fc[4];
        int nf, hcnt, rcnt;

        tbl.push_back(mk(32'h100, enc_i(8, 0, 1, 16'd5),     0, 0, 4, 32'h104, 0, 0, 0, 0));
        tbl.push_back(mk(32'h104, enc_i(8, 0, 2, 16'd7),     2, 0, 6, 32'h108, 0, 0, 0, 0));
        tbl.push_back(mk(32'h108, enc_r(1, 2, 3, 6'h20),     0, 0, 4, 32'h10C, 0, 0, 0, 0));
        tbl.push_back(mk(32'h10C, enc_i(6'h2B, 0, 3, 16'h54), 0, 0, 4, 32'h110, 1, 1, 32'h54, 32'd12));
        tbl.push_back(mk(32'h110, enc_r(1, 2, 4, 6'h22),     0, 0, 4, 32'h114, 0, 0, 0, 0));
        tbl.push_back(mk(32'h114, enc_i(6'h2B, 0, 4, 16'h58), 0, 2, 6, 32'h118, 1, 1, 32'h58, 32'hFFFF_FFFE));
        tbl.push_back(mk(32'h118, enc_r(1, 2, 5, 6'h24),     0, 0, 4, 32'h11C, 0, 0, 0, 0));
        tbl.push_back(mk(32'h11C, enc_i(6'h2B, 0, 5, 16'h5C), 0, 0, 4, 32'h120, 1, 1, 32'h5C, 32'd5));
        tbl.push_back(mk(32'h120, enc_r(1, 2, 6, 6'h25),     0, 0, 4, 32'h124, 0, 0, 0, 0));
        tbl.push_back(mk(32'h124, enc_i(6'h2B, 0, 6, 16'h60), 0, 0, 4, 32'h128, 1, 1, 32'h60, 32'd7));
        tbl.push_back(mk(32'h128, enc_i(8, 0, 7, 16'hFFFF),  0, 0, 4, 32'h12C, 0, 0, 0, 0));
        tbl.push_back(mk(32'h12C, enc_i(8, 0, 8, 16'd1),     0, 0, 4, 32'h130, 0, 0, 0, 0));
        tbl.push_back(mk(32'h130, enc_r(7, 8, 9, 6'h2A),     0, 0, 4, 32'h134, 0, 0, 0, 0));
        tbl.push_back(mk(32'h134, enc_i(6'h2B, 0, 9, 16'h64), 0, 0, 4, 32'h138, 1, 1, 32'h64, 32'd1));
        tbl.push_back(mk(32'h138, enc_r(8, 7, 10, 6'h2A),    0, 0, 4, 32'h13C, 0, 0, 0, 0));
        tbl.push_back(mk(32'h13C, enc_i(6'h2B, 0, 10, 16'h68), 0, 0, 4, 32'h140, 1, 1, 32'h68, 32'd0));
        tbl.push_back(mk(32'h140, enc_i(8, 0, 0, 16'd9),     0, 0, 4, 32'h144, 0, 0, 0, 0));
        tbl.push_back(mk(32'h144, enc_i(6'h2B, 0, 0, 16'h6C), 0, 0, 4, 32'h148, 1, 1, 32'h6C, 32'd0));
        tbl.push_back(mk(32'h148, enc_i(6'h23, 0, 11, 16'h80), 0, 3, 8, 32'h14C, 1, 0, 32'h80, 0));
        tbl.push_back(mk(32'h14C, enc_i(6'h2B, 0, 11, 16'h70), 0, 0, 4, 32'h150, 1, 1, 32'h70, 32'hCAFE_BABE));
        tbl.push_back(mk(32'h150, enc_i(8, 0, 13, 16'h90),   0, 0, 4, 32'h154, 0, 0, 0, 0));
        tbl.push_back(mk(32'h154, enc_i(6'h2B, 13, 1, 16'hFFF8), 0, 0, 4, 32'h158, 1, 1, 32'h88, 32'd5));
        tbl.push_back(mk(32'h158, enc_i(4, 1, 2, 16'd4),     0, 0, 3, 32'h15C, 0, 0, 0, 0));
        tbl.push_back(mk(32'h15C, enc_i(4, 2, 2, 16'd1),     0, 0, 3, 32'h164, 0, 0, 0, 0));
        tbl.push_back(mk(32'h164, enc_j(26'h40),             0, 0, 3, 32'h100, 0, 0, 0, 0));

        for (int i = 0; i < 1024; i++) mem[i] = 32'hFC00_0000;
        foreach (tbl[i]) mem[tbl[i].pc[11:2]] = tbl[i].instr;
        mem[32'h80 >> 2] = 32'hCAFE_BABE;

        // Reset and first fetch
        reset = 1'b1; rst2 = 1'b1; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset pc", 64'(pc), 64'h100);
        chk("reset mem_req", 64'(mem_req), 64'd0);
        chk("reset mem_we", 64'(mem_we), 64'd0);
        chk("reset halted", 64'(halted), 64'd0);
        reset = 1'b0;
        #1;
        chk("req before first edge", 64'(mem_req), 64'd0);
        @(posedge clk); @(negedge clk);
        chk("first fetch", {30'd0, mem_req, mem_we, mem_addr}, {30'd0, 1'b1, 1'b0, 32'h100});

        foreach (tbl[i]) run_instr(tbl[i], i);

        // Taken beq back onto itself, then a stalled fetch aborted by reset
        reset = 1'b1;
        mem[32'h100 >> 2] = enc_j(26'h8);
        mem[32'h20 >> 2]  = enc_i(4, 1, 1, 16'hFFFF);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        run_instr(mk(32'h100, enc_j(26'h8), 0, 0, 3, 32'h20, 0, 0, 0, 0), 100);
        v = mk(32'h20, enc_i(4, 1, 1, 16'hFFFF), 0, 0, 3, 32'h20, 0, 0, 0, 0);
        run_instr(v, 101);
        run_instr(v, 102);
        mem_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("stalled fetch", {30'd0, mem_req, mem_we, mem_addr}, {30'd0, 1'b1, 1'b0, 32'h20});
        chk("stalled pc", 64'(pc), 64'h20);
        reset = 1'b1;
        #1;
        chk("abort mem_req", 64'(mem_req), 64'd0);
        chk("abort pc", 64'(pc), 64'h100);
        mem_ready = 1'b1;
        @(negedge clk);

        // Illegal opcode: halt on dut, skip on dut2 (illegal funct also skipped there)
        mem[32'h100 >> 2] = 32'hFC00_0000;
        mem[32'h104 >> 2] = enc_r(1, 2, 3, 6'h3F);
        mem[32'h108 >> 2] = enc_i(8, 0, 1, 16'd1);
        @(negedge clk);
        reset = 1'b0; rst2 = 1'b0;
        nf = 0; hcnt = 0; rcnt = 0;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); @(negedge clk);
            if (c == 2) chk("halted during decode", 64'(halted), 64'd0);
            if (c >= 3) begin
                if (mem_req) rcnt++;
                if (halted) hcnt++;
            end
            if (req2 && !we2 && nf < 4) begin
                fa[nf] = int'(addr2);
                fc[nf] = c;
                nf++;
            end
        end
        chk("halt cycles", 64'(hcnt), 64'd12);
        chk("halt mem_req", 64'(rcnt), 64'd0);
        chk("nop fetch count", 64'(nf), 64'd4);
        chk("nop fetch1 addr", 64'(fa[1]), 64'h104);
        chk("nop fetch1 cycle", 64'(fc[1]), 64'd3);
        chk("nop fetch2 addr", 64'(fa[2]), 64'h108);
        chk("nop fetch2 cycle", 64'(fc[2]), 64'd6);
        chk("nop fetch3 addr", 64'(fa[3]), 64'h10C);
        chk("nop halted", 64'(halted2), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
